// File: rtl/cmp_sweep_ctrl.sv
// cmp_sweep_ctrl: drives a 5-input comparator across vectors lo..hi, holds each for
// SETTLE cycles, samples Z, and gathers hit statistics. Define CMP_SWEEP_MAP_EN for the per-vector result map.
module cmp_sweep_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [4:0]  lo,
  input  logic [4:0]  hi,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        E,
  input  logic        Z,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [5:0]  hit_count,
  output logic [4:0]  first_hit,
  output logic        first_valid,
  output logic [31:0] result_map
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [4:0] vec_q;
  logic [4:0] hi_q;
  logic [3:0] settle_cnt;
  logic       accept;
  logic       sample_now;
  logic       last_vec;

  assign accept     = (state_q == S_IDLE) && start;
  assign sample_now = (state_q == S_SAMPLE);
  // End check uses the current vector, so hi=31 finishes without wrapping vec.
  assign last_vec   = (vec_q == hi_q);

  assign {A, B, C, D, E} = vec_q;
  assign busy = (state_q == S_WAIT) || (state_q == S_SAMPLE);
  assign done = (state_q == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case leaves
    // state_d unassigned, which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (lo <= hi) ? S_WAIT : S_DONE;
      end
      S_WAIT: begin
        if (abort)                          state_d = S_IDLE;
        else if (settle_cnt == SETTLE_LAST) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (abort)         state_d = S_IDLE;
        else if (last_vec) state_d = S_DONE;
        else               state_d = S_WAIT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q       <= '0;
      hi_q        <= '0;
      settle_cnt  <= '0;
      err         <= 1'b0;
      hit_count   <= '0;
      first_hit   <= '0;
      first_valid <= 1'b0;
    end else begin
      if (accept) begin
        hi_q        <= hi;
        err         <= (lo > hi);
        hit_count   <= '0;
        first_hit   <= '0;
        first_valid <= 1'b0;
        settle_cnt  <= '0;
        if (lo <= hi) vec_q <= lo;
      end

      if ((state_q == S_WAIT) && !abort && (settle_cnt != SETTLE_LAST))
        settle_cnt <= settle_cnt + 4'd1;

      // An aborted SAMPLE still records its Z; only the advance is suppressed.
      if (sample_now) begin
        if (Z) begin
          hit_count <= hit_count + 6'd1;
          if (!first_valid) begin
            first_hit   <= vec_q;
            first_valid <= 1'b1;
          end
        end
        if (!abort && !last_vec) begin
          vec_q      <= vec_q + 5'd1;
          settle_cnt <= '0;
        end
      end
    end
  end

`ifdef CMP_SWEEP_MAP_EN
  logic [31:0] map_q;

  // NOTE: the map is a visible output, so it is reset like any other flop
  // rather than treated as uninitialised storage.
  always_ff @(posedge clk) begin
    if (rst)             map_q         <= '0;
    else if (accept)     map_q         <= '0;
    else if (sample_now) map_q[vec_q]  <= Z;
  end

  assign result_map = map_q;
`else
  assign result_map = '0;
`endif

endmodule

// File: tb/tb_cmp_sweep_ctrl.sv
// Directed bench for cmp_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) each driven
// by a comparator model Z = ({A,B,C,D,E} > 20).
module tb_cmp_sweep_ctrl;

`ifdef CMP_SWEEP_MAP_EN
  localparam logic [31:0] MAP_FULL = 32'hFFE0_0000;
  localparam logic [31:0] MAP_2122 = 32'h0060_0000;
`else
  localparam logic [31:0] MAP_FULL = 32'h0;
  localparam logic [31:0] MAP_2122 = 32'h0;
`endif

  logic clk = 1'b0;
  logic rst, start1, start3, abort;
  logic [4:0] lo, hi;

  logic a1, b1, c1, d1, e1, z1, busy1, done1, err1, fv1;
  logic [5:0] hit1;
  logic [4:0] fh1, vec1;
  logic [31:0] map1;

  logic a3, b3, c3, d3, e3, z3, busy3, done3, err3, fv3;
  logic [5:0] hit3;
  logic [4:0] fh3, vec3;
  logic [31:0] map3;

  int checks = 0;
  int errors = 0;

  assign vec1 = {a1, b1, c1, d1, e1};
  assign vec3 = {a3, b3, c3, d3, e3};
  assign z1 = (vec1 > 5'd20);
  assign z3 = (vec3 > 5'd20);

  always #5 clk = ~clk;

  cmp_sweep_ctrl #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort), .lo(lo), .hi(hi),
    .A(a1), .B(b1), .C(c1), .D(d1), .E(e1), .Z(z1),
    .busy(busy1), .done(done1), .err(err1), .hit_count(hit1),
    .first_hit(fh1), .first_valid(fv1), .result_map(map1)
  );

  cmp_sweep_ctrl #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort), .lo(lo), .hi(hi),
    .A(a3), .B(b3), .C(c3), .D(d3), .E(e3), .Z(z3),
    .busy(busy3), .done(done3), .err(err3), .hit_count(hit3),
    .first_hit(fh3), .first_valid(fv3), .result_map(map3)
  );

  // Advance to just after the next rising edge; all drives and samples happen here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; abort = 1'b0; lo = '0; hi = '0;
    step(); step();
    rst = 1'b0;
    checks++;
    if ({vec1, busy1, done1, err1, hit1, fh1, fv1, map1} !== '0) begin
      errors++;
      $display("FAIL reset_dut1 got vec=%0d busy=%0b done=%0b err=%0b hit=%0d fh=%0d fv=%0b map=%0h expected all 0",
               vec1, busy1, done1, err1, hit1, fh1, fv1, map1);
    end
    checks++;
    if ({vec3, busy3, done3, err3, hit3, fh3, fv3, map3} !== '0) begin
      errors++;
      $display("FAIL reset_dut3 got vec=%0d busy=%0b done=%0b err=%0b hit=%0d expected all 0",
               vec3, busy3, done3, err3, hit3);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({vec1, busy1, done1, err1, hit1, fh1, fv1, map1, busy3, done3} !== '0) begin
        errors++;
        $display("FAIL idle_hold cycle %0d got vec=%0d busy=%0b done=%0b hit=%0d expected all 0",
                 i, vec1, busy1, done1, hit1);
      end
    end
  endtask

  task automatic test_full_sweep();
    int k;
    bit seen;
    lo = 5'd0; hi = 5'd31; start1 = 1'b1;
    step();
    start1 = 1'b0;
    k = 1; seen = 1'b0;
    checks++;
    if (busy1 !== 1'b1) begin
      errors++; $display("FAIL full_busy got %0b expected 1", busy1);
    end
    while (!seen && k <= 200) begin
      if (done1 === 1'b1) seen = 1'b1;
      else begin
        checks++;
        if (vec1 !== 5'((k - 1) / 2)) begin
          errors++; $display("FAIL full_walk cycle %0d got %0d expected %0d", k, vec1, (k - 1) / 2);
        end
        step();
        k++;
      end
    end
    checks++;
    if (!seen || k != 65) begin
      errors++; $display("FAIL full_latency got %0d (seen=%0b) expected 65", k, seen);
    end
    checks++;
    if ({hit1, fh1, fv1, err1} !== {6'd11, 5'd21, 1'b1, 1'b0}) begin
      errors++; $display("FAIL full_stats got hit=%0d fh=%0d fv=%0b err=%0b expected 11 21 1 0", hit1, fh1, fv1, err1);
    end
    checks++;
    if (map1 !== MAP_FULL) begin
      errors++; $display("FAIL full_map got %0h expected %0h", map1, MAP_FULL);
    end
    step();
    checks++;
    if ({done1, busy1} !== 2'b00 || hit1 !== 6'd11) begin
      errors++; $display("FAIL full_after got done=%0b busy=%0b hit=%0d expected 0 0 11", done1, busy1, hit1);
    end
  endtask

  task automatic test_partial_sweep();
    int k;
    bit seen;
    lo = 5'd18; hi = 5'd22; start3 = 1'b1;
    step();
    start3 = 1'b0;
    k = 1; seen = 1'b0;
    while (!seen && k <= 200) begin
      if (done3 === 1'b1) seen = 1'b1;
      else begin
        checks++;
        if (vec3 !== 5'(18 + (k - 1) / 4)) begin
          errors++; $display("FAIL part_walk cycle %0d got %0d expected %0d", k, vec3, 18 + (k - 1) / 4);
        end
        step();
        k++;
      end
    end
    checks++;
    if (!seen || k != 21) begin
      errors++; $display("FAIL part_latency got %0d (seen=%0b) expected 21", k, seen);
    end
    checks++;
    if ({hit3, fh3, fv3, err3} !== {6'd2, 5'd21, 1'b1, 1'b0}) begin
      errors++; $display("FAIL part_stats got hit=%0d fh=%0d fv=%0b err=%0b expected 2 21 1 0", hit3, fh3, fv3, err3);
    end
    checks++;
    if (map3 !== MAP_2122) begin
      errors++; $display("FAIL part_map got %0h expected %0h", map3, MAP_2122);
    end
    step();
  endtask

  task automatic test_error_sweep();
    lo = 5'd9; hi = 5'd3; start1 = 1'b1;
    step();
    start1 = 1'b0;
    checks++;
    if ({done1, err1, busy1} !== 3'b110) begin
      errors++; $display("FAIL err_pulse got done=%0b err=%0b busy=%0b expected 1 1 0", done1, err1, busy1);
    end
    checks++;
    if ({hit1, fh1, fv1, map1} !== '0) begin
      errors++; $display("FAIL err_cleared got hit=%0d fh=%0d fv=%0b map=%0h expected 0", hit1, fh1, fv1, map1);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({busy1, done1, err1} !== 3'b001) begin
        errors++; $display("FAIL err_after cycle %0d got busy=%0b done=%0b err=%0b expected 0 0 1", i, busy1, done1, err1);
      end
    end
  endtask

  task automatic test_abort();
    int n;
    int k;
    bit seen;
    lo = 5'd0; hi = 5'd31; start1 = 1'b1;
    step();
    start1 = 1'b0;
    n = 0;
    while (vec1 !== 5'd23 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (vec1 !== 5'd23) begin
      errors++; $display("FAIL abort_reach got %0d expected 23", vec1);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({busy1, done1} !== 2'b00 || vec1 !== 5'd23) begin
      errors++; $display("FAIL abort_idle got busy=%0b done=%0b vec=%0d expected 0 0 23", busy1, done1, vec1);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({busy1, done1} !== 2'b00) begin
        errors++; $display("FAIL abort_quiet cycle %0d got busy=%0b done=%0b expected 0 0", i, busy1, done1);
      end
    end
    checks++;
    if ({hit1, fh1, fv1, err1} !== {6'd2, 5'd21, 1'b1, 1'b0}) begin
      errors++; $display("FAIL abort_stats got hit=%0d fh=%0d fv=%0b err=%0b expected 2 21 1 0", hit1, fh1, fv1, err1);
    end
    checks++;
    if (map1 !== MAP_2122) begin
      errors++; $display("FAIL abort_map got %0h expected %0h", map1, MAP_2122);
    end
    lo = 5'd5; hi = 5'd5; start1 = 1'b1;
    step();
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || vec1 !== 5'd5) begin
      errors++; $display("FAIL restart_accept got busy=%0b vec=%0d expected 1 5", busy1, vec1);
    end
    k = 1; seen = 1'b0;
    while (!seen && k <= 20) begin
      if (done1 === 1'b1) seen = 1'b1;
      else begin step(); k++; end
    end
    checks++;
    if (!seen || k != 3 || hit1 !== 6'd0) begin
      errors++; $display("FAIL restart_done got latency=%0d hit=%0d expected 3 0", k, hit1);
    end
    step();
  endtask

  task automatic test_collision();
    int k;
    bit seen;
    lo = 5'd18; hi = 5'd22; start1 = 1'b1;
    step();
    lo = 5'd0; hi = 5'd31;
    k = 1; seen = 1'b0;
    while (!seen && k <= 100) begin
      if (k == 9) start1 = 1'b0;
      if (done1 === 1'b1) seen = 1'b1;
      else begin step(); k++; end
    end
    checks++;
    if (!seen || k != 11) begin
      errors++; $display("FAIL collide_latency got %0d (seen=%0b) expected 11", k, seen);
    end
    checks++;
    if ({hit1, fh1} !== {6'd2, 5'd21} || map1 !== MAP_2122) begin
      errors++; $display("FAIL collide_stats got hit=%0d fh=%0d map=%0h expected 2 21 %0h", hit1, fh1, map1, MAP_2122);
    end
    step();
    lo = 5'd0; hi = 5'd31; start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int i = 0; i < 50; i++) step();
    checks++;
    if (busy1 !== 1'b1 || hit1 === 6'd0) begin
      errors++; $display("FAIL midsweep_busy got busy=%0b hit=%0d expected 1 nonzero", busy1, hit1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({vec1, busy1, done1, err1, hit1, fh1, fv1, map1} !== '0) begin
      errors++;
      $display("FAIL midsweep_reset got vec=%0d busy=%0b done=%0b err=%0b hit=%0d fh=%0d fv=%0b map=%0h expected all 0",
               vec1, busy1, done1, err1, hit1, fh1, fv1, map1);
    end
    step();
    checks++;
    if ({busy1, done1, vec1} !== '0) begin
      errors++; $display("FAIL reset_stays got busy=%0b done=%0b vec=%0d expected 0 0 0", busy1, done1, vec1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_sweep();
    test_partial_sweep();
    test_error_sweep();
    test_abort();
    test_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
